// File: rtl/test_result_aggregator.sv
// test_result_aggregator
// Collects per-channel done/error reports during a test run and reduces them
// to a single PASS/FAIL verdict, with sticky masks, first-error capture,
// a saturating RUN-cycle counter and an optional timeout.
//
// Handshake: start is a one-cycle request that is only accepted outside RUN.
// ch_done/ch_error are sampled on every rising edge while in RUN and are
// ignored in every other state, so levels and pulses are equally valid.

module test_result_aggregator #(
  parameter int NUM_CH         = 10,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter bit FAIL_FAST      = 1'b0,
  parameter int CNT_W          = 32
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     start,
  input  logic [NUM_CH-1:0]                        ch_done,
  input  logic [NUM_CH-1:0]                        ch_error,
  output logic                                     busy,
  output logic                                     done,
  output logic                                     error,
  output logic                                     timeout,
  output logic [NUM_CH-1:0]                        done_mask,
  output logic [NUM_CH-1:0]                        error_mask,
  output logic                                     first_err_valid,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] first_err_ch,
  output logic [CNT_W-1:0]                         cycle_count
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  // Last cycle_count value at which a still-incomplete run is timed out.
  localparam logic        TO_EN   = (TIMEOUT_CYCLES > 0);
  localparam logic [63:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? 64'(TIMEOUT_CYCLES - 1) : 64'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PASS = 2'd2,
    FAIL = 2'd3
  } state_t;

  state_t state;

  logic [NUM_CH-1:0] done_next;
  logic [NUM_CH-1:0] err_next;
  logic              complete;
  logic              any_err_now;
  logic              at_limit;
  logic [CNT_W-1:0]  cnt_inc;
  logic [CH_W-1:0]   lowest_idx;

  // Mask/counter values that the current edge would commit, plus the
  // completion and timeout conditions evaluated on those sampled inputs.
  always_comb begin
    done_next   = done_mask | ch_done;
    err_next    = error_mask | ch_error;
    complete    = &done_next;
    any_err_now = |ch_error;
    cnt_inc     = (&cycle_count) ? cycle_count : cycle_count + CNT_W'(1);
    at_limit    = TO_EN && (64'(cycle_count) == TO_LAST);
  end

  // Lowest-index channel raising ch_error this cycle (priority to bit 0).
  always_comb begin
    lowest_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_error[i]) lowest_idx = CH_W'(i);
    end
  end

  // Verdict FSM with all result registers updated alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      done_mask       <= '0;
      error_mask      <= '0;
      first_err_valid <= 1'b0;
      first_err_ch    <= '0;
      timeout         <= 1'b0;
      cycle_count     <= '0;
    end else begin
      case (state)
        IDLE, PASS, FAIL: begin
          // Results hold until a new run is armed; channel inputs ignored.
          if (start) begin
            state           <= RUN;
            done_mask       <= '0;
            error_mask      <= '0;
            first_err_valid <= 1'b0;
            first_err_ch    <= '0;
            timeout         <= 1'b0;
            cycle_count     <= '0;
          end
        end
        RUN: begin
          done_mask   <= done_next;
          error_mask  <= err_next;
          cycle_count <= cnt_inc;
          // Only the earliest error cycle is captured.
          if ((error_mask == '0) && any_err_now) begin
            first_err_valid <= 1'b1;
            first_err_ch    <= lowest_idx;
          end
          // Priority: fail-fast error, then completion, then timeout.
          if (FAIL_FAST && any_err_now) begin
            state <= FAIL;
          end else if (complete) begin
            state <= (|err_next) ? FAIL : PASS;
          end else if (at_limit) begin
            state   <= FAIL;
            timeout <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Status flags are pure decodes of the state register.
  assign busy  = (state == RUN);
  assign done  = (state == PASS) || (state == FAIL);
  assign error = (state == FAIL);

endmodule

// File: tb/tb_test_result_aggregator.sv
// Testbench for test_result_aggregator.
// Three configurations share one stimulus stream:
//   dut 0: 10 channels, timeout 20, wait-for-all
//   dut 1: 10 channels, no timeout, fail-fast
//   dut 2: 3 channels (low bits), no timeout, 4-bit saturating counter
// Each run is predicted as a whole from its per-cycle stimulus table.

module tb_test_result_aggregator;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  logic start;
  logic [9:0] ch_done;
  logic [9:0] ch_error;

  always #5 clk = ~clk;

  // ---------------- DUT outputs gathered per instance ----------------
  logic        o_busy[3], o_done[3], o_err[3], o_to[3], o_fev[3];
  logic [9:0]  o_dm[3], o_em[3];
  logic [3:0]  o_fec[3];
  logic [31:0] o_cnt[3];

  logic [2:0] c_dm, c_em;
  logic [1:0] c_fec;
  logic [3:0] c_cnt;

  test_result_aggregator #(.NUM_CH(10), .TIMEOUT_CYCLES(20), .FAIL_FAST(1'b0), .CNT_W(32)) dut_a (
    .clk(clk), .reset(reset), .start(start), .ch_done(ch_done), .ch_error(ch_error),
    .busy(o_busy[0]), .done(o_done[0]), .error(o_err[0]), .timeout(o_to[0]),
    .done_mask(o_dm[0]), .error_mask(o_em[0]), .first_err_valid(o_fev[0]),
    .first_err_ch(o_fec[0]), .cycle_count(o_cnt[0]));

  test_result_aggregator #(.NUM_CH(10), .TIMEOUT_CYCLES(0), .FAIL_FAST(1'b1), .CNT_W(32)) dut_b (
    .clk(clk), .reset(reset), .start(start), .ch_done(ch_done), .ch_error(ch_error),
    .busy(o_busy[1]), .done(o_done[1]), .error(o_err[1]), .timeout(o_to[1]),
    .done_mask(o_dm[1]), .error_mask(o_em[1]), .first_err_valid(o_fev[1]),
    .first_err_ch(o_fec[1]), .cycle_count(o_cnt[1]));

  test_result_aggregator #(.NUM_CH(3), .TIMEOUT_CYCLES(0), .FAIL_FAST(1'b0), .CNT_W(4)) dut_c (
    .clk(clk), .reset(reset), .start(start), .ch_done(ch_done[2:0]), .ch_error(ch_error[2:0]),
    .busy(o_busy[2]), .done(o_done[2]), .error(o_err[2]), .timeout(o_to[2]),
    .done_mask(c_dm), .error_mask(c_em), .first_err_valid(o_fev[2]),
    .first_err_ch(c_fec), .cycle_count(c_cnt));

  assign o_dm[2]  = {7'b0, c_dm};
  assign o_em[2]  = {7'b0, c_em};
  assign o_fec[2] = {2'b0, c_fec};
  assign o_cnt[2] = {28'b0, c_cnt};

  // ---------------- reference model ----------------
  int cfg_nch[3] = '{10, 10, 3};
  int cfg_ff[3]  = '{0, 1, 0};
  int cfg_to[3]  = '{20, 0, 0};
  int cfg_cw[3]  = '{32, 32, 4};

  typedef struct {
    logic        busy, done, err, tmo, fev;
    logic [9:0]  dm, em;
    logic [3:0]  fec;
    logic [31:0] cnt;
    int          endc;
  } exp_t;

  logic [9:0] done_seq[64];
  logic [9:0] err_seq[64];

  int  tests = 0;
  int  fails = 0;
  bit  any_busy = 1'b0;

  // Replays a run's stimulus table against the verdict rules:
  // the c-th RUN edge sees cycle_count == c before it.
  function automatic exp_t predict(input int k, input int len);
    exp_t e;
    logic [9:0] mask, d, x;
    longint unsigned sat;
    bit ended;
    mask = (cfg_nch[k] == 10) ? 10'h3FF : 10'h007;
    sat  = (longint'(1) << cfg_cw[k]) - 1;
    e.dm = '0; e.em = '0; e.fev = 1'b0; e.fec = '0;
    e.err = 1'b0; e.tmo = 1'b0; e.endc = len;
    ended = 1'b0;
    for (int c = 0; c < len && !ended; c++) begin
      d = done_seq[c] & mask;
      x = err_seq[c] & mask;
      if (e.em == 0 && x != 0) begin
        e.fev = 1'b1;
        for (int i = cfg_nch[k] - 1; i >= 0; i--) if (x[i]) e.fec = 4'(i);
      end
      e.dm = e.dm | d;
      e.em = e.em | x;
      if (cfg_ff[k] != 0 && x != 0) begin
        ended = 1'b1; e.endc = c; e.err = 1'b1;
      end else if (e.dm == mask) begin
        ended = 1'b1; e.endc = c; e.err = (e.em != 0);
      end else if (cfg_to[k] > 0 && c == cfg_to[k] - 1) begin
        ended = 1'b1; e.endc = c; e.err = 1'b1; e.tmo = 1'b1;
      end
    end
    e.busy = !ended;
    e.done = ended;
    if (ended) e.cnt = (longint'(e.endc + 1) > sat) ? 32'(sat) : 32'(e.endc + 1);
    else       e.cnt = (longint'(len) > sat) ? 32'(sat) : 32'(len);
    return e;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic cmp_dut(input string tag, input int k, input exp_t e);
    chk($sformatf("%s_d%0d_busy", tag, k), 64'(o_busy[k]), 64'(e.busy));
    chk($sformatf("%s_d%0d_done", tag, k), 64'(o_done[k]), 64'(e.done));
    chk($sformatf("%s_d%0d_error", tag, k), 64'(o_err[k]), 64'(e.err));
    chk($sformatf("%s_d%0d_timeout", tag, k), 64'(o_to[k]), 64'(e.tmo));
    chk($sformatf("%s_d%0d_done_mask", tag, k), 64'(o_dm[k]), 64'(e.dm));
    chk($sformatf("%s_d%0d_error_mask", tag, k), 64'(o_em[k]), 64'(e.em));
    chk($sformatf("%s_d%0d_fev", tag, k), 64'(o_fev[k]), 64'(e.fev));
    chk($sformatf("%s_d%0d_fec", tag, k), 64'(o_fec[k]), 64'(e.fec));
    chk($sformatf("%s_d%0d_cnt", tag, k), 64'(o_cnt[k]), 64'(e.cnt));
  endtask

  task automatic check_zero(input string tag);
    exp_t z;
    z.busy = 0; z.done = 0; z.err = 0; z.tmo = 0; z.fev = 0;
    z.dm = 0; z.em = 0; z.fec = 0; z.cnt = 0; z.endc = 0;
    for (int k = 0; k < 3; k++) cmp_dut(tag, k, z);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Asynchronous reset pulse launched away from the clock edge.
  task automatic do_reset(input string tag);
    #2 reset = 1'b1;
    #1 check_zero(tag);
    @(negedge clk);
    reset = 1'b0;
    any_busy = 1'b0;
  endtask

  task automatic clear_seq();
    for (int c = 0; c < 64; c++) begin
      done_seq[c] = '0;
      err_seq[c]  = '0;
    end
  endtask

  task automatic run_test(input string tag, input int len, input bit inj);
    exp_t e[3];
    int minend;
    if (any_busy) do_reset({tag, "_pre_rst"});
    for (int k = 0; k < 3; k++) e[k] = predict(k, len);
    minend = e[0].endc;
    for (int k = 1; k < 3; k++) if (e[k].endc < minend) minend = e[k].endc;
    // Channel inputs on the arming edge must be ignored.
    start    = 1'b1;
    ch_done  = 10'($urandom);
    ch_error = 10'($urandom);
    step();
    for (int c = 0; c < len; c++) begin
      ch_done  = done_seq[c];
      ch_error = err_seq[c];
      start    = inj && (c < minend) && ($urandom_range(0, 3) == 0);
      step();
    end
    start = 1'b0; ch_done = '0; ch_error = '0;
    for (int k = 0; k < 3; k++) cmp_dut(tag, k, e[k]);
    any_busy = e[0].busy || e[1].busy || e[2].busy;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    reset = 1'b1; start = 1'b0; ch_done = '0; ch_error = '0;
    @(negedge clk);
    @(negedge clk);
    check_zero("in_reset");
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ch_done = 10'($urandom); ch_error = 10'($urandom);
      step();
    end
    ch_done = '0; ch_error = '0;
    check_zero("idle_hold");

    // One done bit per cycle -> pass after the 10th edge.
    clear_seq();
    for (int c = 0; c < 10; c++) done_seq[c] = 10'(1 << c);
    run_test("all_done", 12, 1'b0);
    chk("all_done_cnt", 64'(o_cnt[0]), 64'd10);
    chk("all_done_dm", 64'(o_dm[0]), 64'h3FF);
    chk("all_done_pass", 64'({o_done[0], o_err[0]}), 64'b10);

    // Start in PASS re-arms with cleared results.
    start = 1'b1; ch_done = 10'h3FF; ch_error = 10'h3FF;
    step();
    start = 1'b0; ch_done = 10'h001; ch_error = '0;
    chk("rearm_busy", 64'(o_busy[0]), 64'd1);
    chk("rearm_dm", 64'(o_dm[0]), 64'd0);
    chk("rearm_em", 64'(o_em[0]), 64'd0);
    chk("rearm_cnt", 64'(o_cnt[0]), 64'd0);
    step();
    // Start during RUN is ignored: count keeps climbing, masks keep.
    start = 1'b1; ch_done = '0;
    step();
    start = 1'b0;
    chk("run_start_cnt", 64'(o_cnt[0]), 64'd2);
    chk("run_start_dm", 64'(o_dm[0]), 64'h001);
    chk("run_start_busy", 64'(o_busy[0]), 64'd1);
    any_busy = 1'b1;

    // Error pulse 0x024 at cycle 3, then all done.
    clear_seq();
    for (int c = 0; c < 10; c++) done_seq[c] = 10'(1 << c);
    err_seq[3] = 10'h024;
    run_test("err_then_done", 12, 1'b0);
    chk("err_then_done_em", 64'(o_em[0]), 64'h024);
    chk("err_then_done_fec", 64'(o_fec[0]), 64'd2);
    chk("err_then_done_fail", 64'({o_err[0], o_to[0]}), 64'b10);

    // Fail-fast on channel 7 error at cycle 5 with partial done.
    clear_seq();
    for (int c = 0; c <= 5; c++) done_seq[c] = 10'(1 << c);
    err_seq[5] = 10'h080;
    run_test("fail_fast", 10, 1'b1);
    chk("fail_fast_fec", 64'(o_fec[1]), 64'd7);
    chk("fail_fast_dm", 64'(o_dm[1]), 64'h03F);
    chk("fail_fast_cnt", 64'(o_cnt[1]), 64'd6);

    // Channel 9 never done -> timeout at cycle_count 20.
    clear_seq();
    for (int c = 0; c < 9; c++) done_seq[c] = 10'(1 << c);
    run_test("timeout", 25, 1'b1);
    chk("timeout_cnt", 64'(o_cnt[0]), 64'd20);
    chk("timeout_flag", 64'(o_to[0]), 64'd1);
    chk("timeout_dm", 64'(o_dm[0]), 64'h1FF);

    // Final done together with error[0] on the same edge.
    clear_seq();
    for (int c = 0; c < 10; c++) done_seq[c] = 10'(1 << c);
    err_seq[9] = 10'h001;
    run_test("done_and_err", 11, 1'b0);
    chk("done_and_err_fail", 64'({o_err[0], o_to[0]}), 64'b10);

    // Reset mid-RUN discards everything; block then idles.
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ch_done = 10'h003; ch_error = 10'h004;
      step();
    end
    do_reset("mid_run_rst");
    for (int i = 0; i < 3; i++) begin
      ch_done = 10'($urandom); ch_error = 10'($urandom);
      step();
    end
    ch_done = '0; ch_error = '0;
    check_zero("post_rst_idle");

    // Randomized runs: dense or sparse done, occasional errors.
    for (int r = 0; r < 30; r++) begin
      int len, mode;
      len  = $urandom_range(5, 40);
      mode = $urandom_range(0, 2);
      clear_seq();
      for (int c = 0; c < len; c++) begin
        if (mode == 0) done_seq[c] = 10'($urandom & $urandom);
        else if ($urandom_range(0, 7) == 0) done_seq[c] = 10'(1 << $urandom_range(0, 9));
        if (mode != 2 && $urandom_range(0, 15) == 0) err_seq[c] = 10'(1 << $urandom_range(0, 9));
      end
      run_test($sformatf("rand%0d", r), len, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
